bytebeat_pcm_mixer: RTL and testbench

- Sits between the bytebeat generator bank and the PWM audio stage.
- Accepts up to NUM_CH valid/ready PCM sample streams (unsigned, midscale-centred) and keeps the latest sample per channel.
- Once per output sample period it sums the enabled channels as signed offsets, clips, and emits one mixed unsigned sample with a one-cycle valid strobe.
- Mixes sequentially, one channel per clock, so only a single adder is needed.

---
 rtl/bytebeat_pcm_mixer.sv | 219 +++++++++++++++++++++
 tb/tb_bytebeat_pcm_mixer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bytebeat_pcm_mixer.sv
// bytebeat_pcm_mixer
// Keeps the latest sample of each PCM input channel and, once per output
// sample period, sums the enabled channels as signed offsets from midscale
// (one channel per clock through a single adder), clips the sum and emits
// one unsigned mixed sample with a one-cycle valid strobe.
// Optional feature: define MIXER_GAIN_EN to add a 2-bit 'gain' input that
// arithmetic-shifts the accumulated sum right before clipping.
module bytebeat_pcm_mixer #(
    parameter int NUM_CH   = 8,
    parameter int W        = 8,
    parameter int TICK_DIV = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH*W-1:0] ch_pcm,
    input  logic [NUM_CH-1:0]   ch_vld,
    output logic [NUM_CH-1:0]   ch_rdy,
    input  logic [NUM_CH-1:0]   ch_en,
`ifdef MIXER_GAIN_EN
    input  logic [1:0]          gain,
`endif
    output logic [W-1:0]        mix_out,
    output logic                mix_vld,
    output logic                tick
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = W + $clog2(NUM_CH) + 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic signed [AW-1:0] MID_A   = AW'(1 << (W - 1));
    localparam logic signed [AW-1:0] POS_LIM = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] NEG_LIM = AW'(-(1 << (W - 1)));
    localparam logic [W-1:0]         MID_W   = W'(1 << (W - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SAT  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [IW-1:0]          idx_r;
    logic [IW-1:0]          idx_next_s;
    logic                   idx_last_s;
    logic [CW-1:0]          cnt_r;
    logic                   tick_r;
    logic [NUM_CH-1:0]      en_q_r;
    logic [NUM_CH-1:0]      rdy_r;
    logic [W-1:0]           hold_r [NUM_CH];
    logic signed [AW-1:0]   acc_r;
    logic signed [AW-1:0]   term_s;
    logic signed [AW-1:0]   shifted_s;
    logic [W-1:0]           sat_s;
    logic [W-1:0]           mix_out_r;
    logic                   mix_vld_r;
`ifdef MIXER_GAIN_EN
    logic [1:0]             gain_q_r;
`endif

    assign ch_rdy  = rdy_r;
    assign mix_out = mix_out_r;
    assign mix_vld = mix_vld_r;
    assign tick    = tick_r;

    assign idx_last_s = (idx_r == IW'(NUM_CH - 1));

    // Free-running output period counter and registered wrap strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == CW'(TICK_DIV - 1));
            if (cnt_r == CW'(TICK_DIV - 1)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Next state and channel index of the sequential mix.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_r) begin
                    state_next_s = ST_ACC;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = idx_r;
                end
            end
            ST_ACC: begin
                idx_next_s = idx_r + IW'(1);
                if (idx_last_s) begin
                    state_next_s = ST_SAT;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_SAT: begin
                state_next_s = ST_IDLE;
                idx_next_s   = '0;
            end
            default: begin
                state_next_s = ST_IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // FSM state and index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
        end
    end

    // Ready is registered: only the channel being read by the adder next cycle is refused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_r <= '1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                rdy_r[i] <= !((state_next_s == ST_ACC) && (idx_next_s == IW'(i)));
            end
        end
    end

    // Latest-sample hold registers; a new accepted sample overwrites the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hold_r[i] <= MID_W;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_vld[i] && rdy_r[i]) begin
                    hold_r[i] <= ch_pcm[i*W +: W];
                end else begin
                    hold_r[i] <= hold_r[i];
                end
            end
        end
    end

    // Signed offset of the current channel, zero when that channel is disabled.
    always_comb begin
        term_s = '0;
        if (en_q_r[idx_r]) begin
            term_s = $signed({{(AW - W){1'b0}}, hold_r[idx_r]}) - MID_A;
        end else begin
            term_s = '0;
        end
    end

    // Optional attenuation, then clip to the signed sample range and re-bias to unsigned.
    always_comb begin
`ifdef MIXER_GAIN_EN
        shifted_s = acc_r >>> gain_q_r;
`else
        shifted_s = acc_r;
`endif
        sat_s = MID_W;
        if (shifted_s > POS_LIM) begin
            sat_s = '1;
        end else if (shifted_s < NEG_LIM) begin
            sat_s = '0;
        end else begin
            sat_s = shifted_s[W-1:0] ^ MID_W;
        end
    end

    // Mix datapath: enable snapshot, accumulation and output update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q_r    <= '0;
            acc_r     <= '0;
            mix_out_r <= MID_W;
            mix_vld_r <= 1'b0;
`ifdef MIXER_GAIN_EN
            gain_q_r  <= 2'd0;
`endif
        end else begin
            mix_vld_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tick_r) begin
                        en_q_r   <= ch_en;
                        acc_r    <= '0;
`ifdef MIXER_GAIN_EN
                        gain_q_r <= gain;
`endif
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_r + term_s;
                end
                ST_SAT: begin
                    mix_out_r <= sat_s;
                    mix_vld_r <= 1'b1;
                end
                default: begin
                    acc_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bytebeat_pcm_mixer.sv
// Self-checking bench for bytebeat_pcm_mixer (NUM_CH=8, W=8, TICK_DIV=16).
// Directed steps followed by randomized mixes, checked against a simple
// arithmetic model of the mix (sum of offsets, shift, clip, re-bias).
module tb_bytebeat_pcm_mixer;

    localparam int NUM_CH   = 8;
    localparam int W        = 8;
    localparam int TICK_DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ch_pcm;
    logic [7:0]  ch_vld;
    logic [7:0]  ch_rdy;
    logic [7:0]  ch_en;
    logic [1:0]  gain;
    logic [7:0]  mix_out;
    logic        mix_vld;
    logic        tick;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  hold_m [8];
    logic [7:0]  last_out;

    bytebeat_pcm_mixer #(.NUM_CH(NUM_CH), .W(W), .TICK_DIV(TICK_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ch_pcm  (ch_pcm),
        .ch_vld  (ch_vld),
        .ch_rdy  (ch_rdy),
        .ch_en   (ch_en),
`ifdef MIXER_GAIN_EN
        .gain    (gain),
`endif
        .mix_out (mix_out),
        .mix_vld (mix_vld),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of signed offsets of enabled channels, shifted, clipped, re-biased.
    function automatic logic [7:0] ref_mix(input logic [7:0] en, input int g);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (en[i]) s += int'(hold_m[i]) - 128;
        end
        s = s >>> g;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s + 128);
    endfunction

    // Drive a batch of samples for one cycle while the mixer is idle.
    task automatic push(input logic [7:0] mask, input logic [63:0] data);
        ch_pcm = data;
        ch_vld = mask;
        @(negedge clk);
        ch_vld = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) hold_m[i] = data[i*8 +: 8];
        end
    endtask

    // Wait (bounded) for the tick strobe; returns at the negedge of the tick-high cycle.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (tick === 1'b1) seen = 1'b1;
        end
        check("tick_seen", {31'd0, seen}, 32'd1);
    endtask

    // One full mix period: checks strobes, ready pattern and result; optionally injects
    // a write to channel inj_ch during its own ACC cycle.
    task automatic run_mix(input logic [7:0] exp, input int inj_ch, input logic [7:0] inj_val);
        logic [7:0] en_save;
        logic [1:0] gain_save;
        logic [7:0] exp_rdy;
        wait_tick();
        en_save   = ch_en;
        gain_save = gain;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            exp_rdy = (k >= 1 && k <= 8) ? ~(8'h01 << (k - 1)) : 8'hFF;
            check("ch_rdy", {24'd0, ch_rdy}, {24'd0, exp_rdy});
            check("mix_vld", {31'd0, mix_vld}, {31'd0, (k == 10)});
            check("tick_low", {31'd0, tick}, 32'd0);
            check("mix_out", {24'd0, mix_out}, {24'd0, (k >= 10) ? exp : last_out});
            if (k == 2) begin
                ch_en = ~en_save;
                gain  = ~gain_save;
            end
            if (k == 11) begin
                ch_en = en_save;
                gain  = gain_save;
            end
            if (inj_ch >= 0 && k == inj_ch + 1) begin
                ch_pcm[inj_ch*8 +: 8] = inj_val;
                ch_vld = 8'h01 << inj_ch;
            end
            if (inj_ch >= 0 && k == inj_ch + 3) begin
                ch_vld = 8'h00;
                hold_m[inj_ch] = inj_val;
            end
        end
        last_out = exp;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  en_r;
        logic [63:0] dat_r;
        logic [7:0]  msk_r;
        logic [7:0]  exp_r;
        logic [7:0]  inj_v;
        int          g_r;
        int          inj;

        rst_n  = 1'b0;
        ch_pcm = 64'd0;
        ch_vld = 8'h00;
        ch_en  = 8'h00;
        gain   = 2'd0;
        for (int i = 0; i < 8; i++) hold_m[i] = 8'h80;
        last_out = 8'h80;

        // 1: reset state and first (silent) mix
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mix_out", {24'd0, mix_out}, 32'h80);
        check("rst_mix_vld", {31'd0, mix_vld}, 32'd0);
        check("rst_ch_rdy", {24'd0, ch_rdy}, 32'hFF);
        check("rst_tick", {31'd0, tick}, 32'd0);
        run_mix(8'h80, -1, 8'h00);

        // 2: single channel passes through
        push(8'h01, {56'd0, 8'hC0});
        ch_en = 8'h01;
        run_mix(8'hC0, -1, 8'h00);

        // 3: two-channel sum, positive and negative clipping
        push(8'h03, {48'd0, 8'h70, 8'hA0});
        ch_en = 8'h03;
        run_mix(8'h90, -1, 8'h00);
        push(8'h03, {48'd0, 8'hF0, 8'hF0});
        run_mix(8'hFF, -1, 8'h00);
        push(8'h03, {48'd0, 8'h00, 8'h00});
        run_mix(8'h00, -1, 8'h00);

        // 4: write refused during channel 3's ACC cycle, lands afterwards
        push(8'h08, {32'd0, 8'h90, 24'd0});
        ch_en = 8'h08;
        run_mix(8'h90, 3, 8'hD0);
        run_mix(8'hD0, -1, 8'h00);

        // 5: reset during ACC aborts the mix and restores midscale holds
        push(8'h01, {56'd0, 8'hF0});
        ch_en = 8'hFF;
        wait_tick();
        repeat (5) @(negedge clk);
        check("acc_idx4_rdy", {24'd0, ch_rdy}, 32'hEF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) hold_m[i] = 8'h80;
        last_out = 8'h80;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("abort_vld", {31'd0, mix_vld}, 32'd0);
            check("abort_out", {24'd0, mix_out}, 32'h80);
        end
        run_mix(8'h80, -1, 8'h00);
        push(8'h04, {40'd0, 8'h30, 16'd0});
        run_mix(8'h30, -1, 8'h00);

`ifdef MIXER_GAIN_EN
        // 6: gain attenuation
        push(8'h03, {48'd0, 8'hF0, 8'hF0});
        ch_en = 8'h03;
        gain  = 2'd1;
        run_mix(8'hF0, -1, 8'h00);
        gain  = 2'd0;
        run_mix(8'hFF, -1, 8'h00);
`endif

        // Randomized mixes against the reference model
        for (int r = 0; r < 24; r++) begin
            dat_r = {$urandom, $urandom};
            msk_r = 8'($urandom_range(0, 255));
            en_r  = 8'($urandom_range(0, 255));
`ifdef MIXER_GAIN_EN
            g_r = $urandom_range(0, 3);
`else
            g_r = 0;
`endif
            inj   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            inj_v = 8'($urandom_range(0, 255));
            push(msk_r, dat_r);
            ch_en = en_r;
            gain  = 2'(g_r);
            exp_r = ref_mix(en_r, g_r);
            run_mix(exp_r, inj, inj_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
